// File: rtl/fir_dec_avg_if.sv
// Sample stream bundle for fir_dec_avg: input samples x and averaged output y,
// each with its own valid/ready handshake.
interface fir_dec_avg_if #(
  parameter int W_IN = 8
);
  logic [W_IN-1:0] x;
  logic            x_valid;
  logic            x_ready;
  logic [W_IN-1:0] y;
  logic            y_valid;
  logic            y_ready;

  modport master (
    output x, x_valid, y_ready,
    input  x_ready, y, y_valid
  );

  modport slave (
    input  x, x_valid, y_ready,
    output x_ready, y, y_valid
  );
endinterface

// File: rtl/fir_dec_avg.sv
// Decimate-by-2**LOG2R integrate-and-dump averager with a 2-entry output FIFO.
// Define DEC_ROUND_EN for round-half-up scaling; the default build truncates (floor).
module fir_dec_avg #(
  parameter int W_IN  = 8,
  parameter int LOG2R = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  fir_dec_avg_if.slave     bus,
  output logic [LOG2R-1:0] phase
);
  localparam int WA = W_IN + LOG2R;
  localparam logic [LOG2R-1:0] PH_LAST = '1;

  logic signed [WA-1:0] acc_q, acc_d;
  logic signed [WA-1:0] sum;
  logic [LOG2R-1:0]     phase_q, phase_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [W_IN-1:0]      head_q, head_d;
  logic [W_IN-1:0]      tail_q, tail_d;
  logic                 run_q;
  logic                 x_fire, y_fire, dump;
  logic [W_IN-1:0]      avg;

  // x_ready stays low through reset and rises on the first edge after release
  assign bus.x_ready = run_q && (cnt_q != 2'd2);
  assign bus.y_valid = (cnt_q != 2'd0);
  assign bus.y       = head_q;
  assign phase       = phase_q;

  assign x_fire = bus.x_valid && bus.x_ready;
  assign y_fire = bus.y_valid && bus.y_ready;
  assign sum    = acc_q + {{LOG2R{bus.x[W_IN-1]}}, bus.x};

`ifdef DEC_ROUND_EN
  localparam logic [WA:0] HALF = (WA+1)'(1) << (LOG2R - 1);
  logic [WA:0] sum_r;
  logic        unused_rnd;
  assign sum_r      = {sum[WA-1], sum} + HALF;
  assign avg        = sum_r[WA-1:LOG2R];
  assign unused_rnd = ^{sum_r[WA], sum_r[LOG2R-1:0]};
`else
  // taking the upper bits of the sum is the arithmetic (floor) shift
  assign avg = sum[WA-1:LOG2R];
`endif

  always_comb begin
    acc_d   = acc_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    dump    = 1'b0;

    if (clr) begin
      acc_d   = '0;
      phase_d = '0;
    end else if (x_fire) begin
      if (phase_q == PH_LAST) begin
        acc_d   = '0;
        phase_d = '0;
        dump    = 1'b1;
      end else begin
        acc_d   = sum;
        phase_d = phase_q + LOG2R'(1);
      end
    end

    // head_q is the FIFO head and keeps its value after the last pop
    case (cnt_q)
      2'd0: begin
        if (dump) begin
          head_d = avg;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (dump && y_fire) begin
          head_d = avg;
        end else if (dump) begin
          tail_d = avg;
          cnt_d  = 2'd2;
        end else if (y_fire) begin
          cnt_d = 2'd0;
        end
      end
      2'd2: begin
        if (y_fire) begin
          head_d = tail_q;
          cnt_d  = 2'd1;
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q   <= '0;
      phase_q <= '0;
      cnt_q   <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      run_q   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fir_dec_avg.sv
// Scoreboard bench for fir_dec_avg (R=4); expectations follow DEC_ROUND_EN when defined.
module tb_fir_dec_avg;
  localparam int W_IN  = 8;
  localparam int LOG2R = 2;
  localparam int R     = 1 << LOG2R;

`ifdef DEC_ROUND_EN
  localparam int EXP_BASIC = 2;
  localparam int EXP_NEG   = 0;
  localparam int EXP_BP0   = 3;
  localparam int EXP_BP1   = 7;
`else
  localparam int EXP_BASIC = 1;
  localparam int EXP_NEG   = -1;
  localparam int EXP_BP0   = 2;
  localparam int EXP_BP1   = 6;
`endif

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic [LOG2R-1:0] phase;

  fir_dec_avg_if #(.W_IN(W_IN)) bus ();

  fir_dec_avg #(.W_IN(W_IN), .LOG2R(LOG2R)) dut (
    .clk   (clk),
    .reset (rst_n),
    .clr   (clr),
    .bus   (bus.slave),
    .phase (phase)
  );

  int n_chk;
  int n_err;
  int q[$];
  int macc;
  int mph;
  logic armed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int scale(input int s);
`ifdef DEC_ROUND_EN
    return (s + R/2) >>> LOG2R;
`else
    return s >>> LOG2R;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // Reference model and scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      macc = 0;
      mph  = 0;
    end else if (armed) begin
      check("phase",   int'(phase),       mph);
      check("y_valid", int'(bus.y_valid), int'(q.size() != 0));
      check("x_ready", int'(bus.x_ready), int'(q.size() < 2));
      if (bus.y_valid && bus.y_ready && q.size() > 0)
        check("y", int'($signed(bus.y)), q.pop_front());
      if (clr) begin
        macc = 0;
        mph  = 0;
      end else if (bus.x_valid && bus.x_ready) begin
        macc += int'($signed(bus.x));
        if (mph == R-1) begin
          q.push_back(scale(macc));
          macc = 0;
          mph  = 0;
        end else begin
          mph++;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int v);
    int n;
    bus.x       = W_IN'(v);
    bus.x_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.x_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.x_valid = 1'b0;
  endtask

  task automatic send4(input int a, input int b, input int c, input int d);
    send(a); send(b); send(c); send(d);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || bus.y_valid) && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    clr = 1'b0;
    bus.x = 8'sd5;
    bus.x_valid = 1'b1;
    bus.y_ready = 1'b1;

    repeat (3) begin
      @(negedge clk);
      check("rst_y",       int'(bus.y),       0);
      check("rst_y_valid", int'(bus.y_valid), 0);
      check("rst_x_ready", int'(bus.x_ready), 0);
      check("rst_phase",   int'(phase),       0);
    end
    #1;
    rst_n = 1'b1;
    bus.x_valid = 1'b0;
    #1;
    check("rel_pre_edge", int'(bus.x_ready), 0);
    @(negedge clk);
    check("rel_post_edge", int'(bus.x_ready), 1);
    @(posedge clk);
    #1;

    // basic average and first-output latency
    send4(1, 1, 2, 2);
    @(negedge clk);
    check("basic_latency", int'(bus.y_valid), 1);
    check("basic_y", int'($signed(bus.y)), EXP_BASIC);
    drain();

    send4(-1, -1, 0, 0);
    drain();
    check("neg_y", int'($signed(bus.y)), EXP_NEG);
    send4(127, 127, 127, 127);
    drain();
    check("max_y", int'($signed(bus.y)), 127);
    send4(-128, -128, -128, -128);
    drain();
    check("min_y", int'($signed(bus.y)), -128);
    check("hold_after_pop", int'(bus.y_valid), 0);

    // backpressure: buffer fills after 2 blocks
    bus.y_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(i);
    bus.x = 8'sd9;
    bus.x_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_stall", int'(bus.x_ready), 0);
      check("bp_head", int'($signed(bus.y)), EXP_BP0);
    end
    @(posedge clk);
    #1;
    bus.x_valid = 1'b0;
    bus.y_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_resume", int'(bus.x_ready), 1);
    check("bp_second", int'($signed(bus.y)), EXP_BP1);
    @(posedge clk);
    #1;
    for (int i = 9; i <= 12; i++) send(i);
    drain();

    // push and pop in the same cycle with one entry buffered
    bus.y_ready = 1'b0;
    send4(8, 8, 8, 8);
    send(20); send(20); send(20);
    bus.y_ready = 1'b1;
    send(24);
    @(negedge clk);
    check("pp_valid", int'(bus.y_valid), 1);
    check("pp_y", int'($signed(bus.y)), 21);
    drain();

    // clr mid-block discards the accumulator and the concurrent sample
    bus.y_ready = 1'b0;
    send4(3, 3, 3, 3);
    send(100); send(100);
    bus.x = 8'sd50;
    bus.x_valid = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    bus.x_valid = 1'b0;
    @(negedge clk);
    check("clr_phase", int'(phase), 0);
    check("clr_keep_valid", int'(bus.y_valid), 1);
    check("clr_keep_y", int'($signed(bus.y)), 3);
    @(posedge clk);
    #1;
    send4(4, 4, 4, 4);
    bus.y_ready = 1'b1;
    drain();
    check("clr_after_y", int'($signed(bus.y)), 4);

    // async reset mid-block with data buffered
    bus.y_ready = 1'b0;
    send4(10, 10, 10, 10);
    send(5); send(5);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_y_valid", int'(bus.y_valid), 0);
    check("mrst_y",       int'(bus.y),       0);
    check("mrst_x_ready", int'(bus.x_ready), 0);
    check("mrst_phase",   int'(phase),       0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.y_ready = 1'b1;
    @(posedge clk);
    #1;
    send4(1, 1, 2, 2);
    drain();
    check("mrst_after_y", int'($signed(bus.y)), EXP_BASIC);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fir_dec_avg.md
Name: fir_dec_avg

Overview:
- Decimate-by-R averaging stage directly downstream of the 8-bit FIR filter output.
- Accepts one signed 8-bit sample per valid/ready transfer and sums R consecutive accepted samples (integrate-and-dump).
- Emits one scaled 8-bit average per R inputs through a 2-entry output buffer with valid/ready handshake.
- Feeds the next rate-reduced processing stage.

Parameters:
- W_IN, 8: input and output sample width, signed two's complement.
- LOG2R, 2: log2 of the decimation factor. R = 2**LOG2R; legal range 1..4.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = clear)
- clr  in  1  synchronous clear of accumulator and phase; output buffer untouched
- x  in  W_IN  input sample, signed
- x_valid  in  1  x holds a sample
- x_ready  out  1  block can accept x this cycle
- y  out  W_IN  averaged output sample, signed; head of output buffer
- y_valid  out  1  y holds a sample
- y_ready  in  1  downstream accepts y this cycle
- phase  out  LOG2R  accepted-sample index within the current block, 0..R-1

Behaviour:
- Reset (reset=0, async): accumulator=0, phase=0, buffer empty, y=0, y_valid=0, x_ready=0 while asserted. x_ready=1 from the first clock edge after release.
- Input transfer: occurs when x_valid && x_ready. x_ready = (buffer count < 2); it is registered-state based and never combinationally depends on x_valid.
- Output transfer: occurs when y_valid && y_ready. y_valid = (count > 0).
- Accumulator width: W_IN+LOG2R bits, signed. acc_next = acc + sign-extended x; it cannot overflow.
- Phase counter increments on each input transfer and wraps from R-1 to 0.
- Dump: on an input transfer with phase==R-1:
  - sum = acc + x is scaled and pushed into the buffer.
  - acc is cleared to 0 (not loaded with x).
  - phase goes to 0.
- Scaling (base): y = sum >>> LOG2R, an arithmetic shift (floor). The result always fits in W_IN bits.
- Latency: y_valid rises on the clock edge that accepts the R-th sample, so it is visible the following cycle when the buffer was empty.
- Buffer: 2-entry FIFO, count 0..2, strictly in order.
  - Push and pop in the same cycle with count=1: count stays 1 and the new sample becomes the head.
  - With count=2, x_ready=0, so no push can occur and no sample is ever dropped.
  - A pop with count=2 re-enables x_ready next cycle.
- Backpressure: y_ready held 0 stalls input after at most 2*R accepted samples.
- y holds its value while y_valid && !y_ready. After the last pop, y holds the last value and y_valid=0.
- clr=1: acc=0 and phase=0 next cycle; any input transfer in the same cycle is discarded (clr wins). Buffer contents, y and y_valid are unaffected.
- Reset mid-block or with a full buffer: everything is discarded immediately and the state returns to the reset values.

Optional Feature:
- Macro: DEC_ROUND_EN
- Defined: round-half-up scaling, y = (sum + 2**(LOG2R-1)) >>> LOG2R. The add is done in W_IN+LOG2R+1 bits. Max result is floor(127.5) = 127, so no saturation logic is needed.
- Undefined: truncating (floor) scaling as in Behaviour.
- All other timing and handshaking is identical in both builds.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles with x_valid=1 -> y=0, y_valid=0, x_ready=0, phase=0. One edge after release -> x_ready=1.
- Basic average, R=4, y_ready=1, inputs 1,1,2,2 contiguous -> one output, cycle after 4th accept. Truncating build: y=1. DEC_ROUND_EN build: y=2. phase sequence 0,1,2,3,0.
- Negative/extremes:
  - -1,-1,0,0 -> y=-1 (trunc) / 0 (round).
  - four times 127 -> y=127 (both builds).
  - four times -128 -> y=-128 (both builds).
- Backpressure: y_ready=0, stream 1..12 continuously -> x_ready falls after 8 accepts with buffer holding 2 and 6 (trunc). Then y_ready=1 -> pops 2 then 6 in order; x_ready returns the cycle after the first pop.
- Simultaneous push/pop: count=1, 4th sample accepted while y_ready=1 -> count stays 1 and the new average appears on y next cycle.
- clr mid-block: accept 100,100, then clr=1 with x_valid=1 and x=50 -> x discarded, phase=0. Then 4,4,4,4 -> y=4. An already-buffered output is unaffected.
